precision_narrow: RTL and testbench
===================================

PRECISION_NARROW -- requirements
Module: precision_narrow

Interface
REQ-001 SHALL have parameter EXP_WIDTH_IN, default 5, input exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH_IN, default 10, input fraction width.
REQ-003 SHALL have parameter EXP_WIDTH_OUT, default 4, output exponent width; EXP_WIDTH_OUT <= EXP_WIDTH_IN.
REQ-004 SHALL have parameter FRAC_WIDTH_OUT, default 3, output fraction width; 2 <= FRAC_WIDTH_OUT < FRAC_WIDTH_IN.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  float_num_in is valid.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 float_num_in  input  EXP_WIDTH_IN+FRAC_WIDTH_IN+1  wide IEEE-style float: sign, exponent, fraction.
REQ-011 out_valid  output  1  float_num_out is valid.
REQ-012 out_ready  input  1  consumer accepts output.
REQ-013 float_num_out  output  EXP_WIDTH_OUT+FRAC_WIDTH_OUT+1  narrowed float.
REQ-014 out_invalid, out_overflow, out_underflow, out_inexact  output  1 each  per-result flags, valid with out_valid.
REQ-015 flag_clr  input  1  clears sticky flags.
REQ-016 sticky_flags  output  4  accumulated {invalid, overflow, underflow, inexact}.

Function
REQ-017 Input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
REQ-018 Pipeline SHALL have two register stages: S1 (decode, rebias, rounding-increment select), S2 (rounding add, pack, flags).
REQ-019 Latency SHALL be 2 cycles from input transfer to out_valid; throughput is 1 result/cycle while out_ready=1.
REQ-020 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S1 moves to S2; in_ready = S1 can load (combinational path from out_ready allowed).
REQ-021 With out_valid=1 and out_ready=0, float_num_out and per-result flags SHALL hold stable; no data loss or duplication.
REQ-022 Biases: BIAS_x = 2^(EXP_WIDTH_x-1)-1; unbiased exponent e = exp_in - BIAS_IN.
REQ-023 NaN input (exp all ones, frac!=0) -> {sign, all-ones exp, 1 followed by zeros}, out_invalid=1.
REQ-024 Inf input -> {sign, all-ones exp, zero frac}, no flags.
REQ-025 Zero or subnormal input -> signed zero; subnormal input also sets out_underflow and out_inexact.
REQ-026 Normal input with e < 1-BIAS_OUT (checked before rounding) -> signed zero, out_underflow=1, out_inexact=1.
REQ-027 Otherwise fraction rounds to nearest, ties to even: guard = first dropped bit, sticky = OR of remaining dropped bits; increment when guard && (sticky || kept LSB).
REQ-028 out_inexact=1 when any dropped bit is nonzero.
REQ-029 Rounding carry out of fraction SHALL zero the fraction and increment the exponent.
REQ-030 If e > BIAS_OUT, or post-rounding exponent field reaches all ones -> signed Inf, out_overflow=1, out_inexact=1.
REQ-031 Sign SHALL pass through unchanged in all cases.
REQ-032 sticky_flags |= per-result flags on each output transfer; flag_clr zeroes them; same-cycle flag_clr and transfer -> flags from that transfer remain set.

Reset
REQ-033 On rst: S1/S2 valid cleared, out_valid=0, sticky_flags=0, float_num_out=0, per-result flags=0; in_ready=1 in the cycle after rst deasserts.
REQ-034 Reset mid-operation SHALL discard in-flight data; no output transfer in the cycle after rst.

Verification (default params, FP16 -> E4M3)
REQ-035 0x3C00 (1.0), out_ready=1 -> 0x38 two cycles later, no flags.
REQ-036 Ties: 0x3C40 -> 0x38 inexact; 0x3CC0 -> 0x3A inexact; carry 0x3FC0 -> 0x40 inexact.
REQ-037 Range: 0x5B80 (240) -> 0x77 no flags; 0x5C00 (256) -> 0x78 overflow+inexact; 0x2000 (2^-7) -> 0x00 underflow+inexact.
REQ-038 Specials: 0x7E00 -> 0x7C invalid; 0xFC00 -> 0xF8; 0x8000 -> 0x80 no flags.
REQ-039 Backpressure: stream of 6 inputs, out_ready toggled 0/1 randomly -> all 6 outputs in order, held stable while stalled, in_ready=0 when both stages full and out_ready=0.
REQ-040 Sticky: overflow beat then flag_clr the same cycle as an invalid beat's output transfer -> sticky_flags = 4'b1000.

Source files
------------

// File: rtl/precision_narrow.sv
// precision_narrow: 2-stage float narrowing (FP16->E4M3 default) with RNE, flags, sticky flags; ports clk,rst,in_valid/in_ready/float_num_in,out_valid/out_ready/float_num_out,out_invalid/overflow/underflow/inexact,flag_clr,sticky_flags
module precision_narrow #(
  parameter int EXP_WIDTH_IN   = 5,
  parameter int FRAC_WIDTH_IN  = 10,
  parameter int EXP_WIDTH_OUT  = 4,
  parameter int FRAC_WIDTH_OUT = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [EXP_WIDTH_IN+FRAC_WIDTH_IN:0]     float_num_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [EXP_WIDTH_OUT+FRAC_WIDTH_OUT:0]   float_num_out,
  output logic                                    out_invalid,
  output logic                                    out_overflow,
  output logic                                    out_underflow,
  output logic                                    out_inexact,
  input  logic                                    flag_clr,
  output logic [3:0]                              sticky_flags
);
  localparam int EWI = EXP_WIDTH_IN;
  localparam int FWI = FRAC_WIDTH_IN;
  localparam int EWO = EXP_WIDTH_OUT;
  localparam int FWO = FRAC_WIDTH_OUT;
  localparam int BIAS_IN  = 2**(EWI-1) - 1;
  localparam int BIAS_OUT = 2**(EWO-1) - 1;
  logic           w_sign;
  logic [EWI-1:0] w_exp;
  logic [FWI-1:0] w_frac, w_rem;
  logic [FWO-1:0] w_kept;
  logic           w_guard, w_sticky;
  int             w_e;
  logic           w_norm, w_inc;
  logic [EWO-1:0] w_eo;
  logic [FWO-1:0] w_fo;
  logic [3:0]     w_fl;
  logic           r1_valid, r1_sign, r1_norm, r1_inc;
  logic [EWO-1:0] r1_exp;
  logic [FWO-1:0] r1_frac;
  logic [3:0]     r1_fl;
  logic           r2_valid;
  logic [EWO+FWO:0] r2_out;
  logic [3:0]     r2_fl, r_sticky;
  logic           w_s2_load, w_oxfer, w_ovf;
  logic [FWO:0]   w_sum;
  logic [EWO-1:0] w_e2;
  logic [EWO+FWO:0] w_res;
  assign w_sign   = float_num_in[EWI+FWI];
  assign w_exp    = float_num_in[FWI +: EWI];
  assign w_frac   = float_num_in[FWI-1:0];
  assign w_kept   = w_frac[FWI-1 -: FWO];
  assign w_guard  = w_frac[FWI-FWO-1];
  // shifting out kept+guard leaves exactly the sticky bits, even when none remain
  assign w_rem    = w_frac << (FWO + 1);
  assign w_sticky = |w_rem;
  assign w_e      = int'({1'b0, w_exp}) - BIAS_IN;
  // S1 resolves every special case to its final encoding; only the round path is touched in S2
  always_comb begin
    w_norm = 1'b0;
    w_inc  = 1'b0;
    w_fl   = 4'b0000;
    w_eo   = '1;
    w_fo   = '0;
    if (&w_exp) begin
      w_fo    = |w_frac ? {1'b1, {(FWO-1){1'b0}}} : '0;
      w_fl[3] = |w_frac;
    end else if (~|w_exp) begin
      w_eo = '0;
      w_fl = |w_frac ? 4'b0011 : 4'b0000;
    end else if (w_e < 1 - BIAS_OUT) begin
      w_eo = '0;
      w_fl = 4'b0011;
    end else if (w_e > BIAS_OUT) begin
      w_fl = 4'b0101;
    end else begin
      w_norm  = 1'b1;
      w_eo    = EWO'(w_e + BIAS_OUT);
      w_fo    = w_kept;
      w_inc   = w_guard & (w_sticky | w_kept[0]);
      w_fl[0] = w_guard | w_sticky;
    end
  end
  // exponent tops out at all-ones-minus-one before rounding, so the carry can only reach all ones, never wrap
  assign w_sum = {1'b0, r1_frac} + {{FWO{1'b0}}, r1_inc};
  assign w_e2  = r1_exp + {{(EWO-1){1'b0}}, w_sum[FWO]};
  assign w_ovf = r1_norm & (&w_e2);
  assign w_res = w_ovf ? {r1_sign, {EWO{1'b1}}, {FWO{1'b0}}} : {r1_sign, w_e2, w_sum[FWO-1:0]};
  assign w_s2_load = ~r2_valid | out_ready;
  assign w_oxfer   = r2_valid & out_ready;
  assign in_ready  = ~r1_valid | w_s2_load;
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r2_out   <= '0;
      r2_fl    <= '0;
      r_sticky <= '0;
    end else begin
      if (in_ready) r1_valid <= in_valid;
      if (in_ready && in_valid) begin
        r1_sign <= w_sign;
        r1_norm <= w_norm;
        r1_inc  <= w_inc;
        r1_exp  <= w_eo;
        r1_frac <= w_fo;
        r1_fl   <= w_fl;
      end
      if (w_s2_load) r2_valid <= r1_valid;
      if (w_s2_load && r1_valid) begin
        r2_out <= w_res;
        r2_fl  <= r1_fl | {1'b0, w_ovf, 1'b0, w_ovf};
      end
      r_sticky <= (flag_clr ? 4'b0000 : r_sticky) | (w_oxfer ? r2_fl : 4'b0000);
    end
  end
  assign out_valid     = r2_valid;
  assign float_num_out = r2_out;
  assign out_invalid   = r2_fl[3];
  assign out_overflow  = r2_fl[2];
  assign out_underflow = r2_fl[1];
  assign out_inexact   = r2_fl[0];
  assign sticky_flags  = r_sticky;
endmodule

// File: tb/tb_precision_narrow.sv
// tb_precision_narrow: directed vector bench for precision_narrow (FP16 -> E4M3)
module tb_precision_narrow;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic [15:0] float_num_in;
  logic [7:0]  float_num_out;
  logic        out_invalid, out_overflow, out_underflow, out_inexact;
  logic [3:0]  sticky_flags;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] din;
    logic [7:0]  dout;
    logic [3:0]  fl;
  } vec_t;
  vec_t tv[20];
  precision_narrow dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .float_num_in(float_num_in), .out_valid(out_valid), .out_ready(out_ready),
    .float_num_out(float_num_out), .out_invalid(out_invalid), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact), .flag_clr(flag_clr),
    .sticky_flags(sticky_flags)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] res();
    return {float_num_out, out_invalid, out_overflow, out_underflow, out_inexact};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send_check(input vec_t v);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    float_num_in = v.din;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("latency_%h", v.din), k, 2);
    chk($sformatf("result_%h", v.din), {20'd0, res()}, {20'd0, v.dout, v.fl});
  endtask
  initial begin
    logic [11:0] q[$];
    logic [11:0] held;
    logic        stalled;
    int          sent, got;
    tv[0]  = '{16'h3C00, 8'h38, 4'b0000};
    tv[1]  = '{16'h3C40, 8'h38, 4'b0001};
    tv[2]  = '{16'h3CC0, 8'h3A, 4'b0001};
    tv[3]  = '{16'h3FC0, 8'h40, 4'b0001};
    tv[4]  = '{16'h5B80, 8'h77, 4'b0000};
    tv[5]  = '{16'h5C00, 8'h78, 4'b0101};
    tv[6]  = '{16'h2000, 8'h00, 4'b0011};
    tv[7]  = '{16'h7E00, 8'h7C, 4'b1000};
    tv[8]  = '{16'hFC00, 8'hF8, 4'b0000};
    tv[9]  = '{16'h8000, 8'h80, 4'b0000};
    tv[10] = '{16'h5BC0, 8'h78, 4'b0101};
    tv[11] = '{16'h0001, 8'h00, 4'b0011};
    tv[12] = '{16'h2400, 8'h08, 4'b0000};
    tv[13] = '{16'h3C01, 8'h38, 4'b0001};
    tv[14] = '{16'h3C60, 8'h39, 4'b0001};
    tv[15] = '{16'hBC00, 8'hB8, 4'b0000};
    tv[16] = '{16'h7C00, 8'h78, 4'b0000};
    tv[17] = '{16'hFE01, 8'hFC, 4'b1000};
    tv[18] = '{16'hA000, 8'h80, 4'b0011};
    tv[19] = '{16'h23FF, 8'h00, 4'b0011};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    flag_clr = 1'b0;
    float_num_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    chk("reset_sticky", {28'd0, sticky_flags}, 0);
    chk("reset_result", {20'd0, res()}, 0);
    foreach (tv[i]) send_check(tv[i]);
    @(negedge clk);
    chk("sticky_accum", {28'd0, sticky_flags}, 32'hF);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("sticky_clear", {28'd0, sticky_flags}, 0);
    send_check(tv[5]);
    @(negedge clk);
    chk("sticky_ovf", {28'd0, sticky_flags}, 32'h5);
    send_check(tv[7]);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    chk("sticky_clr_same_cycle", {28'd0, sticky_flags}, 32'h8);
    sent = 0;
    got = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      @(negedge clk);
      if (stalled) chk("bp_hold", {20'd0, res()}, {20'd0, held});
      out_ready = 1'($urandom_range(0, 1));
      in_valid = sent < 6;
      float_num_in = sent < 6 ? tv[sent+1].din : 16'h0;
      #1;
      if (q.size() == 2 && !out_ready) chk("bp_full_in_ready", {31'd0, in_ready}, 0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_order_%0d", got), {20'd0, res()}, {20'd0, q.pop_front()});
        got++;
      end
      stalled = out_valid && !out_ready;
      held = res();
      if (in_valid && in_ready) begin
        q.push_back({tv[sent+1].dout, tv[sent+1].fl});
        sent++;
      end
    end
    chk("bp_count", got, 6);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    float_num_in = 16'h3C00;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_sticky", {28'd0, sticky_flags}, 0);
    repeat (2) @(negedge clk);
    chk("midrst_no_output", {31'd0, out_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
